// File: rtl/mux_seq_defs_pkg.sv
// Shared definitions for the mux select sequencer: state encoding, widths,
// dwell bounds and a helper that keeps the dwell parameter in range.
package mux_seq_defs;

  localparam int SEL_W     = 3;
  localparam int CAP_W     = 8;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 15;
  localparam int CNT_W     = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_SAMPLE = S_SAMPLE,
    ST_DONE   = S_DONE
  } state_e;

  localparam logic [SEL_W-1:0] SEL_LO = 3'd0;
  localparam logic [SEL_W-1:0] SEL_HI = 3'd7;

  // Out-of-range dwell values are pinned to the nearest legal bound so the
  // counter reload always fits and is never negative.
  function automatic int clamp_dwell(input int d);
    if (d < DWELL_MIN) begin
      return DWELL_MIN;
    end else if (d > DWELL_MAX) begin
      return DWELL_MAX;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/mux_select_sequencer_dwell_timer.sv
// Loadable down-counter that times the settle interval of each select code.
// It reloads to DWELL-1 and reports when it has reached zero.
module dwell_timer
  import mux_seq_defs::*;
#(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(clamp_dwell(DWELL) - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over load, load wins over decrement; never underflow.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {CNT_W{1'b0}};
    end else if (load_i) begin
      count_d = RELOAD;
    end else if (dec_i && (count_q != {CNT_W{1'b0}})) begin
      count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mux_select_sequencer.sv
// Walks the 8-to-1 mux select through all eight codes, holds each for the
// dwell time, samples the mux output back and assembles the parallel word.
module mux_select_sequencer
  import mux_seq_defs::*;
#(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             abort,
  input  logic             mux_out,
  output logic             sl2,
  output logic             sl1,
  output logic             sl0,
  output logic             busy,
  output logic             sample_valid,
  output logic             done,
  output logic [CAP_W-1:0] data
);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               dir_q;
  logic               busy_q;
  logic               sv_q;
  logic               done_q;
  logic [CAP_W-1:0]   data_q;

  logic               timer_load_s;
  logic               timer_dec_s;
  logic               timer_clr_s;
  logic               timer_zero_s;
  logic               last_code_s;

  // Final code of the scan depends on the latched direction.
  assign last_code_s = dir_q ? (sel_q == SEL_LO) : (sel_q == SEL_HI);
  assign timer_clr_s = abort;

  // Timer control: load on accepted start and between codes, count in SETTLE.
  always_comb begin
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    case (state_q)
      ST_IDLE:   timer_load_s = start && !abort;
      ST_SETTLE: timer_dec_s  = !abort && !timer_zero_s;
      ST_SAMPLE: timer_load_s = !abort && !last_code_s;
      default: begin
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
      end
    endcase
  end

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load_s),
    .dec_i  (timer_dec_s),
    .clr_i  (timer_clr_s),
    .zero_o (timer_zero_s)
  );

  // Sequencing FSM with registered select, handshake and capture outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_LO;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      sv_q    <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= {CAP_W{1'b0}};
    end else begin
      sv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q <= ST_SETTLE;
            sel_q   <= dir ? SEL_HI : SEL_LO;
            dir_q   <= dir;
            busy_q  <= 1'b1;
            data_q  <= {CAP_W{1'b0}};
          end else begin
            sel_q  <= SEL_LO;
            busy_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_LO;
            busy_q  <= 1'b0;
          end else if (timer_zero_s) begin
            state_q <= ST_SAMPLE;
            sv_q    <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_LO;
            busy_q  <= 1'b0;
          end else begin
            data_q[sel_q] <= mux_out;
            if (last_code_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SETTLE;
              sel_q   <= dir_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
            end
          end
        end
        ST_DONE: begin
          // Abort here has the same effect as the normal return to IDLE.
          state_q <= ST_IDLE;
          sel_q   <= SEL_LO;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= SEL_LO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sl2          = sel_q[2];
  assign sl1          = sel_q[1];
  assign sl0          = sel_q[0];
  assign busy         = busy_q;
  assign sample_valid = sv_q;
  assign done         = done_q;
  assign data         = data_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: two instances (DWELL=2 and DWELL=1) each
// driven by a behavioural 8-to-1 mux built from a pattern byte.
module tb_mux_select_sequencer;

  typedef struct packed {
    int cyc;
    int sel;
  } exp_t;

  typedef struct {
    int         dut;
    logic       dir;
    logic [7:0] pat;
    logic [7:0] exp_data;
    int         done_off;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_s;
  logic [1:0] dir_s;
  logic [1:0] abort_s;
  logic [7:0] pat_s [2];
  logic [1:0] mux_w;
  logic [1:0] sl2_w, sl1_w, sl0_w;
  logic [1:0] busy_w, sv_w, done_w;
  logic [7:0] data_w [2];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mux_w[0] = pat_s[0][{sl2_w[0], sl1_w[0], sl0_w[0]}];
  assign mux_w[1] = pat_s[1][{sl2_w[1], sl1_w[1], sl0_w[1]}];

  mux_select_sequencer #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .dir(dir_s[0]), .abort(abort_s[0]),
    .mux_out(mux_w[0]), .sl2(sl2_w[0]), .sl1(sl1_w[0]), .sl0(sl0_w[0]),
    .busy(busy_w[0]), .sample_valid(sv_w[0]), .done(done_w[0]), .data(data_w[0])
  );

  mux_select_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .dir(dir_s[1]), .abort(abort_s[1]),
    .mux_out(mux_w[1]), .sl2(sl2_w[1]), .sl1(sl1_w[1]), .sl0(sl0_w[1]),
    .busy(busy_w[1]), .sample_valid(sv_w[1]), .done(done_w[1]), .data(data_w[1])
  );

  function automatic int sel_of(input int d);
    return int'({sl2_w[d], sl1_w[d], sl0_w[d]});
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_exp(input int d, input int c, input int s);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) next_cycle();
  endtask

  // Scoreboard side: each sample pulse must match the oldest expected sample.
  task automatic mon(input int d);
    exp_t e;
    if (sv_w[d]) begin
      if (qsize(d) == 0) begin
        chk($sformatf("unexpected_sample_dut%0d", d), cyc, -1);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("sample_cycle_dut%0d", d), cyc, e.cyc);
        chk($sformatf("sample_sel_dut%0d", d), sel_of(d), e.sel);
      end
    end
    if (done_w[d]) done_cnt[d] = done_cnt[d] + 1;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic chk_idle_outputs(input string tag, input int d);
    chk({tag, "_sel"},  sel_of(d), 0);
    chk({tag, "_busy"}, busy_w[d], 0);
    chk({tag, "_sv"},   sv_w[d],   0);
    chk({tag, "_done"}, done_w[d], 0);
    chk({tag, "_data"}, data_w[d], 0);
  endtask

  // Full scan from the current cycle t; expected samples queued up front.
  task automatic do_scan(input vec_t v);
    int t;
    int dw;
    int seen;
    int dc;
    dw = (v.dut == 0) ? 2 : 1;
    t  = cyc;
    dc = done_cnt[v.dut];
    pat_s[v.dut]   = v.pat;
    dir_s[v.dut]   = v.dir;
    start_s[v.dut] = 1'b1;
    for (int k = 1; k <= 8; k++) push_exp(v.dut, t + k * (dw + 1), v.dir ? 8 - k : k - 1);
    next_cycle();
    start_s[v.dut] = 1'b0;
    chk("busy_after_start", busy_w[v.dut], 1);
    chk("first_sel", sel_of(v.dut), v.dir ? 7 : 0);
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      if (done_w[v.dut]) begin
        seen = cyc;
        break;
      end
      next_cycle();
    end
    chk("done_cycle", seen, t + v.done_off);
    chk("data_word", data_w[v.dut], v.exp_data);
    next_cycle();
    chk("idle_busy", busy_w[v.dut], 0);
    chk("idle_sel", sel_of(v.dut), 0);
    chk("done_once", done_cnt[v.dut] - dc, 1);
    chk("queue_drained", qsize(v.dut), 0);
  endtask

  initial begin
    vec_t vecs [5];
    int   t;
    int   dc;

    vecs[0] = '{0, 1'b0, 8'hA5, 8'hA5, 25};
    vecs[1] = '{0, 1'b1, 8'hA5, 8'hA5, 25};
    vecs[2] = '{1, 1'b0, 8'h3C, 8'h3C, 17};
    vecs[3] = '{1, 1'b1, 8'h96, 8'h96, 17};
    vecs[4] = '{0, 1'b1, 8'h01, 8'h01, 25};

    rst      = 1'b1;
    start_s  = 2'b00;
    dir_s    = 2'b00;
    abort_s  = 2'b00;
    pat_s[0] = 8'h00;
    pat_s[1] = 8'h00;

    repeat (3) next_cycle();
    chk_idle_outputs("reset_dut2", 0);
    chk_idle_outputs("reset_dut1", 1);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 5; i++) do_scan(vecs[i]);

    // Abort partway through: three bits captured, then back to IDLE.
    t = cyc;
    dc = done_cnt[0];
    pat_s[0] = 8'hFF;
    dir_s[0] = 1'b0;
    start_s[0] = 1'b1;
    for (int k = 1; k <= 3; k++) push_exp(0, t + 3 * k, k - 1);
    next_cycle();
    start_s[0] = 1'b0;
    wait_until(t + 10);
    abort_s[0] = 1'b1;
    next_cycle();
    abort_s[0] = 1'b0;
    chk("abort_busy", busy_w[0], 0);
    chk("abort_sel", sel_of(0), 0);
    chk("abort_sv", sv_w[0], 0);
    chk("abort_data", data_w[0], 8'h07);
    wait_until(t + 30);
    chk("abort_no_done", done_cnt[0] - dc, 0);
    chk("abort_queue", qsize(0), 0);
    chk("abort_data_held", data_w[0], 8'h07);

    // Start pulses mid-scan and in the DONE cycle are ignored.
    t = cyc;
    dc = done_cnt[0];
    pat_s[0] = 8'hA5;
    dir_s[0] = 1'b0;
    start_s[0] = 1'b1;
    for (int k = 1; k <= 8; k++) push_exp(0, t + 3 * k, k - 1);
    next_cycle();
    start_s[0] = 1'b0;
    wait_until(t + 5);
    dir_s[0] = 1'b1;
    start_s[0] = 1'b1;
    next_cycle();
    start_s[0] = 1'b0;
    wait_until(t + 25);
    chk("ign_done_cycle", done_w[0], 1);
    start_s[0] = 1'b1;
    next_cycle();
    start_s[0] = 1'b0;
    dir_s[0] = 1'b0;
    chk("ign_idle_busy", busy_w[0], 0);
    next_cycle();
    chk("ign_still_idle_busy", busy_w[0], 0);
    chk("ign_still_idle_sel", sel_of(0), 0);
    wait_until(t + 32);
    chk("ign_done_once", done_cnt[0] - dc, 1);
    chk("ign_data", data_w[0], 8'hA5);
    chk("ign_queue", qsize(0), 0);

    // Synchronous reset mid-scan, then a fresh scan completes.
    t = cyc;
    pat_s[0] = 8'hFF;
    dir_s[0] = 1'b0;
    start_s[0] = 1'b1;
    for (int k = 1; k <= 8; k++) push_exp(0, t + 3 * k, k - 1);
    next_cycle();
    start_s[0] = 1'b0;
    wait_until(t + 8);
    chk("pre_reset_data", data_w[0], 8'h03);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    q0.delete();
    chk_idle_outputs("mid_reset", 0);
    wait_until(t + 10);
    begin
      vec_t v;
      v = '{0, 1'b0, 8'h5A, 8'h5A, 25};
      do_scan(v);
    end

    repeat (4) next_cycle();
    chk("final_q0", qsize(0), 0);
    chk("final_q1", qsize(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
